// File: rtl/led_pwm_if.sv
// CPU store/read-back bus for the LED PWM control register.
// Ports: we (store strobe), addr (data address), din (store data), rdata (read-back).
// master = CPU side, slave = led_pwm side.
interface led_pwm_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] rdata;

  modport master (output we, addr, din, input rdata);
  modport slave  (input we, addr, din, output rdata);
endinterface

// File: rtl/led_pwm.sv
// LED brightness PWM with a CPU-visible control register, optional blinking.
// Ports: clk, rstn (sync, active-low), bus (led_pwm_if.slave), led_in[7:0] pattern,
// led_out[7:0] registered pin drive. Blinking is compiled in by defining LED_PWM_BLINK_EN.
module led_pwm #(
  parameter int          CLK_DIV   = 16,
  parameter logic [31:0] CTRL_ADDR = 32'hFFFF_0018
) (
  input  logic       clk,
  input  logic       rstn,
  led_pwm_if.slave   bus,
  input  logic [7:0] led_in,
  output logic [7:0] led_out
);

  localparam logic [15:0] PRESC_MAX = 16'(CLK_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]  pend_duty_q, pend_duty_d;
  logic        pend_en_q, pend_en_d;
  logic [7:0]  act_duty_q, act_duty_d;
  logic        act_en_q, act_en_d;
  logic [7:0]  act_led_q, act_led_d;
  logic [7:0]  led_out_q, led_out_d;

  logic sel, wr, tick, boundary, on_raw, blink_off;

`ifdef LED_PWM_BLINK_EN
  logic        pend_blink_en_q, pend_blink_en_d;
  logic [3:0]  pend_blink_rate_q, pend_blink_rate_d;
  logic        act_blink_en_q, act_blink_en_d;
  logic [3:0]  act_blink_rate_q, act_blink_rate_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic        blink_last;
`endif

  assign sel      = (bus.addr == CTRL_ADDR);
  assign wr       = bus.we && sel;
  assign tick     = (presc_q == PRESC_MAX);
  assign boundary = tick && (pwm_cnt_q == 8'hFF);

  // Only the active copy drives the output, so a CPU write mid-period is
  // invisible until the next boundary.
  assign on_raw = act_en_q && ((act_duty_q == 8'hFF) || (pwm_cnt_q < act_duty_q));

`ifdef LED_PWM_BLINK_EN
  assign blink_off  = act_blink_en_q && blink_phase_q;
  assign blink_last = (blink_cnt_q == ((16'd1 << act_blink_rate_q) - 16'd1));
  assign bus.rdata  = sel ? {16'h0, pend_blink_rate_q, 2'b00, pend_blink_en_q, pend_en_q, pend_duty_q}
                          : 32'h0;
  logic unused_din;
  assign unused_din = ^{bus.din[31:16], bus.din[11:10]};
`else
  assign blink_off = 1'b0;
  assign bus.rdata = sel ? {16'h0, 7'h0, pend_en_q, pend_duty_q} : 32'h0;
  logic unused_din;
  assign unused_din = ^{bus.din[31:9]};
`endif

  always_comb begin
    presc_d     = tick ? 16'h0 : presc_q + 16'd1;
    pwm_cnt_d   = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    pend_duty_d = pend_duty_q;
    pend_en_d   = pend_en_q;
    act_duty_d  = act_duty_q;
    act_en_d    = act_en_q;
    act_led_d   = act_led_q;
`ifdef LED_PWM_BLINK_EN
    pend_blink_en_d   = pend_blink_en_q;
    pend_blink_rate_d = pend_blink_rate_q;
    act_blink_en_d    = act_blink_en_q;
    act_blink_rate_d  = act_blink_rate_q;
    blink_cnt_d       = blink_cnt_q;
    blink_phase_d     = blink_phase_q;
`endif

    if (wr) begin
      pend_duty_d = bus.din[7:0];
      pend_en_d   = bus.din[8];
`ifdef LED_PWM_BLINK_EN
      pend_blink_en_d   = bus.din[9];
      pend_blink_rate_d = bus.din[15:12];
`endif
    end

    // Active state loads from the *next* pending value so a write landing on
    // the boundary cycle wins over the old pending contents.
    if (boundary) begin
      act_duty_d = pend_duty_d;
      act_en_d   = pend_en_d;
      act_led_d  = led_in;
`ifdef LED_PWM_BLINK_EN
      act_blink_en_d   = pend_blink_en_d;
      act_blink_rate_d = pend_blink_rate_d;
      // Counting uses the settings of the period just ending; turning blink
      // off resets the phase so it restarts cleanly when re-enabled.
      if (!act_blink_en_d) begin
        blink_cnt_d   = 16'h0;
        blink_phase_d = 1'b0;
      end else if (act_blink_en_q) begin
        if (blink_last) begin
          blink_cnt_d   = 16'h0;
          blink_phase_d = !blink_phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 16'd1;
        end
      end
`endif
    end

    led_out_d = (on_raw && !blink_off) ? act_led_q : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      presc_q     <= '0;
      pwm_cnt_q   <= '0;
      pend_duty_q <= '0;
      pend_en_q   <= 1'b0;
      act_duty_q  <= '0;
      act_en_q    <= 1'b0;
      act_led_q   <= '0;
      led_out_q   <= '0;
`ifdef LED_PWM_BLINK_EN
      pend_blink_en_q   <= 1'b0;
      pend_blink_rate_q <= '0;
      act_blink_en_q    <= 1'b0;
      act_blink_rate_q  <= '0;
      blink_cnt_q       <= '0;
      blink_phase_q     <= 1'b0;
`endif
    end else begin
      presc_q     <= presc_d;
      pwm_cnt_q   <= pwm_cnt_d;
      pend_duty_q <= pend_duty_d;
      pend_en_q   <= pend_en_d;
      act_duty_q  <= act_duty_d;
      act_en_q    <= act_en_d;
      act_led_q   <= act_led_d;
      led_out_q   <= led_out_d;
`ifdef LED_PWM_BLINK_EN
      pend_blink_en_q   <= pend_blink_en_d;
      pend_blink_rate_q <= pend_blink_rate_d;
      act_blink_en_q    <= act_blink_en_d;
      act_blink_rate_q  <= act_blink_rate_d;
      blink_cnt_q       <= blink_cnt_d;
      blink_phase_q     <= blink_phase_d;
`endif
    end
  end

  assign led_out = led_out_q;

endmodule

// File: doc/led_pwm.md
LED_PWM -- requirements
Module: led_pwm

Interface
REQ-001 Parameter CLK_DIV, default 16: clk cycles per PWM step; legal range 1..65535.
REQ-002 Parameter CTRL_ADDR, default 32'hFFFF_0018: address of the brightness control register.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 we  input  1  CPU store strobe, one cycle per store.
REQ-006 addr  input  32  CPU data address.
REQ-007 din  input  32  CPU store data.
REQ-008 led_in  input  8  LED pattern from the upstream LED register.
REQ-009 rdata  output  32  combinational read-back of the control register.
REQ-010 led_out  output  8  registered drive to the physical LED pins.

Function
REQ-011 sel = (addr == CTRL_ADDR); write occurs when we && sel; writes to other addresses are ignored.
REQ-012 A write loads the pending register: duty = din[7:0], en = din[8], blink_en = din[9], blink_rate = din[15:12]; other din bits are ignored.
REQ-013 rdata = {16'b0, blink_rate, 2'b00, blink_en, en, duty} from the pending register when sel, else 32'h0.
REQ-014 Prescaler counts 0..CLK_DIV-1 and wraps to 0; tick is asserted in the cycle it equals CLK_DIV-1.
REQ-015 8-bit pwm_cnt increments on each tick and wraps 255->0.
REQ-016 Period boundary = a tick while pwm_cnt==255.
REQ-017 At each period boundary, the active register loads the pending register and led_in is sampled into act_led.
REQ-018 A write in the same cycle as a boundary is loaded into the active register at that boundary, taking precedence over the old pending value.
REQ-019 on_raw = act_en && (act_duty==255 || pwm_cnt < act_duty); duty 0 gives always off and duty 255 gives always on.
REQ-020 led_out[i] <= act_led[i] && on_raw && !blink_off, evaluated every cycle; this is one cycle of latency from pwm_cnt/active state.
REQ-021 act_led and active settings never change mid-period, so a mid-period CPU write produces no glitch.

Reset
REQ-022 With rstn low at a clk edge, the following are cleared to 0: prescaler, pwm_cnt, pending and active registers, act_led, blink counter, blink phase, and led_out.
REQ-023 A reset asserted mid-period abandons the period; the first boundary after release occurs 256*CLK_DIV cycles later.
REQ-024 rdata reads 32'h0 during reset and immediately after it.

Configuration
REQ-025 Macro LED_PWM_BLINK_EN compiles blinking in or out.
REQ-026 With LED_PWM_BLINK_EN defined, a blink_cnt counts period boundaries.
REQ-027 With LED_PWM_BLINK_EN defined, when act_blink_en is set and blink_cnt reaches (1<<act_blink_rate)-1, blink_cnt clears and blink_phase toggles.
REQ-028 With LED_PWM_BLINK_EN defined, blink_off = act_blink_en && blink_phase.
REQ-029 With LED_PWM_BLINK_EN defined, clearing act_blink_en also clears blink_cnt and blink_phase at the same boundary.
REQ-030 Without LED_PWM_BLINK_EN, there is no blink logic, blink_off is constant 0, din[9] and din[15:12] are ignored, and rdata[15:9] read as 0.

Verification (CLK_DIV=1 unless noted)
REQ-031 Reset, then led_in=8'hA5 with no writes -> led_out stays 8'h00 (en=0).
REQ-032 Write 32'h1FF, led_in=8'hA5 -> after the first boundary, led_out is constant 8'hA5 every cycle.
REQ-033 Write 32'h140, led_in=8'hFF -> led_out=8'hFF for exactly 64 of every 256 cycles, at pwm_cnt 0..63 (delayed one cycle).
REQ-034 Write 32'h1FF, then a mid-period write of 32'h100 -> full-on output continues until the next boundary, then led_out=8'h00; rdata reads 32'h100 immediately.
REQ-035 With LED_PWM_BLINK_EN, write 32'h13FF -> led_out alternates 2 periods (512 cycles) on and 2 periods off; without the macro, led_out is steady on and rdata=32'h1FF.
REQ-036 Write 32'h1FF at addr 32'hFFFF_0010, then pulse rstn low mid-period -> no effect from the write; led_out=0 the cycle after the reset edge and the next boundary occurs 256 cycles after release.
